// File: rtl/spdch_pkg.sv
// Shared definitions for the spdch round-robin arbiter slice.
package spdch_pkg;

    // Arbiter has exactly two states: nobody owns the resource, or one requester does.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Pointer value after reset: 3, so the first search starts at requester 0.
    localparam logic [1:0] PTR_RST = 2'd3;

    // Expand a 2-bit requester index into a 4-bit one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/spdch_rrpe4.sv
// Rotating priority encoder: picks the first eligible request at or after
// ptr+1, wrapping cyclically, with the excluded requester masked out.
module spdch_rrpe4
    import spdch_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] excl,
    output logic [1:0] winner,
    output logic       any
);

    logic [3:0] masked;
    logic [1:0] idx;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4) and keep the first eligible hit.
    always_comb begin
        masked = req & ~excl;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (masked[idx] && !any) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spdch_rrarb4.sv
// Four-requester round-robin arbiter with an optional tenure timeout.
// The current owner's one-hot grant doubles as the exclude mask, so a
// release or a timeout always hands the resource to somebody else.
module spdch_rrarb4
    import spdch_pkg::*;
#(
    parameter int maxcyc = 15,
    parameter int cntw   = 4
)
(
    input  logic       ck,
    input  logic       r,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       expire
);

    localparam logic [cntw-1:0] cnt_max  = cntw'(maxcyc);
    localparam logic [cntw-1:0] cnt_last = cntw'(maxcyc - 1);

    arb_state_t      state;
    logic [1:0]      ptr;
    logic [cntw-1:0] tenure;

    logic [1:0] winner;
    logic       any;
    logic       owner_req;
    logic       timeout;

    // In IDLE gnt is zero, so nothing is excluded; in GRANT the owner is.
    spdch_rrpe4 u_pe (
        .req    (req),
        .ptr    (ptr),
        .excl   (gnt),
        .winner (winner),
        .any    (any)
    );

    // Owner still holding its request, and whether its tenure has run out.
    always_comb begin
        owner_req = |(req & gnt);
        timeout   = (maxcyc != 0) && (tenure >= cnt_last);
    end

    // All arbiter state and registered outputs.
    always_ff @(posedge ck) begin
        if (r) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            sel    <= '0;
            busy   <= 1'b0;
            expire <= 1'b0;
            tenure <= '0;
            ptr    <= PTR_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    expire <= 1'b0;
                    tenure <= '0;
                    if (any) begin
                        state <= ST_GRANT;
                        gnt   <= onehot4(winner);
                        sel   <= winner;
                        busy  <= 1'b1;
                        ptr   <= winner;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        expire <= 1'b0;
                        tenure <= '0;
                        if (any) begin
                            gnt <= onehot4(winner);
                            sel <= winner;
                            ptr <= winner;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (timeout && any) begin
                        expire <= 1'b1;
                        tenure <= '0;
                        gnt    <= onehot4(winner);
                        sel    <= winner;
                        ptr    <= winner;
                    end else begin
                        expire <= 1'b0;
                        if (tenure != cnt_max) begin
                            tenure <= tenure + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    expire <= 1'b0;
                    tenure <= '0;
                end
            endcase
        end
    end

endmodule
